reaction_game_fsm: RTL and testbench

//   Multi-round, multi-channel reaction-time game controller (one LED + one button per channel).

---
 rtl/reaction_game_fsm.sv | 133 +++++++++++++
 tb/tb_reaction_game_fsm.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/reaction_game_fsm.sv
// rtl/reaction_game_fsm.sv - multi-round reaction-time game controller
// Lights one random LED per round, times the matching press in ms ticks and keeps the score.
module reaction_game_fsm #(
    parameter int LED_NUM    = 18,
    parameter int MAX_MS     = 2047,
    parameter int ROUNDS     = 10,
    parameter int GAP_MS     = 500,
    parameter int TIMEOUT_MS = 1000,
    localparam int RTW = $clog2(MAX_MS + 1),
    localparam int IW  = $clog2(LED_NUM),
    localparam int HW  = $clog2(ROUNDS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ms_tick,
    input  logic               start,
    input  logic [LED_NUM-1:0] buttons,
    input  logic [IW-1:0]      random_value,
    output logic [LED_NUM-1:0] led_on,
    output logic [HW-1:0]      hits,
    output logic [7:0]         misses,
    output logic [RTW-1:0]     last_rt,
    output logic [RTW-1:0]     best_rt,
    output logic               rt_valid,
    output logic               busy,
    output logic               game_over
);
    localparam logic [RTW-1:0] GAP_END  = RTW'(GAP_MS - 1);
    localparam logic [RTW-1:0] TO_END   = RTW'(TIMEOUT_MS - 1);
    localparam logic [RTW-1:0] MAX_CNT  = RTW'(MAX_MS);
    localparam logic [HW-1:0]  LAST_RND = HW'(ROUNDS - 1);
    localparam logic [IW:0]    LED_N    = (IW + 1)'(LED_NUM);

    typedef enum logic [1:0] {IDLE, GAP, ARMED, DONE} state_t;

    state_t             state;
    logic               start_q;
    logic [LED_NUM-1:0] buttons_q;
    logic [RTW-1:0]     ms_cnt;
    logic [HW-1:0]      round;
    logic               start_e;
    logic [LED_NUM-1:0] btn_e;
    logic [IW-1:0]      tgt_idx;
    logic [7:0]         misses_inc;

    assign start_e    = start & ~start_q;
    assign btn_e      = buttons & ~buttons_q;
    assign misses_inc = (misses == 8'hff) ? misses : misses + 8'd1;

    // The random index spans a power of two, so one wrap folds it into 0..LED_NUM-1.
    always_comb begin
        tgt_idx = random_value;
        if ({1'b0, random_value} >= LED_N)
            tgt_idx = IW'({1'b0, random_value} - LED_N);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            buttons_q <= '0;
            ms_cnt    <= '0;
            round     <= '0;
            led_on    <= '0;
            hits      <= '0;
            misses    <= '0;
            last_rt   <= '0;
            best_rt   <= MAX_CNT;
            rt_valid  <= 1'b0;
            busy      <= 1'b0;
            game_over <= 1'b0;
        end else begin
            start_q   <= start;
            buttons_q <= buttons;
            rt_valid  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_e) begin
                        state     <= GAP;
                        hits      <= '0;
                        misses    <= '0;
                        round     <= '0;
                        ms_cnt    <= '0;
                        best_rt   <= MAX_CNT;
                        busy      <= 1'b1;
                        game_over <= 1'b0;
                    end
                end
                GAP: begin
                    if (btn_e != '0) begin
                        misses <= misses_inc;
                        ms_cnt <= '0;
                    end else if (ms_tick) begin
                        if (ms_cnt == GAP_END) begin
                            ms_cnt <= '0;
                            led_on <= LED_NUM'(1) << tgt_idx;
                            state  <= ARMED;
                        end else begin
                            ms_cnt <= ms_cnt + RTW'(1);
                        end
                    end
                end
                ARMED: begin
                    // A button edge always settles the round, even on the timeout tick.
                    if (btn_e != '0 || (ms_tick && ms_cnt == TO_END)) begin
                        if (btn_e == led_on) begin
                            hits     <= hits + HW'(1);
                            last_rt  <= ms_cnt;
                            rt_valid <= 1'b1;
                            if (ms_cnt < best_rt)
                                best_rt <= ms_cnt;
                        end else begin
                            misses <= misses_inc;
                        end
                        led_on <= '0;
                        ms_cnt <= '0;
                        if (round == LAST_RND) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            game_over <= 1'b1;
                        end else begin
                            round <= round + HW'(1);
                            state <= GAP;
                        end
                    end else if (ms_tick && ms_cnt != MAX_CNT) begin
                        ms_cnt <= ms_cnt + RTW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reaction_game_fsm.sv
// tb/tb_reaction_game_fsm.sv - directed self-checking bench for reaction_game_fsm
module tb_reaction_game_fsm;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ms_tick = 1'b0;
    logic        start = 1'b0;
    logic [17:0] buttons = '0;
    logic [4:0]  random_value = '0;
    logic [17:0] led_on;
    logic [3:0]  hits;
    logic [7:0]  misses;
    logic [10:0] last_rt;
    logic [10:0] best_rt;
    logic        rt_valid;
    logic        busy;
    logic        game_over;

    int n_cmp = 0;
    int n_err = 0;

    reaction_game_fsm dut (
        .clk(clk), .rst_n(rst_n), .ms_tick(ms_tick), .start(start), .buttons(buttons),
        .random_value(random_value), .led_on(led_on), .hits(hits), .misses(misses),
        .last_rt(last_rt), .best_rt(best_rt), .rt_valid(rt_valid), .busy(busy),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ms_tick = 1'b1;
            step();
        end
        ms_tick = 1'b0;
    endtask

    task automatic press(input logic [17:0] mask);
        buttons = mask;
        step();
        buttons = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic hit_round(input logic [4:0] rv, input int rt);
        random_value = rv;
        ticks(500);
        ticks(rt);
        press(18'd1 << rv);
        step();
    endtask

    initial begin
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_led", led_on, 0);
        chk("rst_hits", hits, 0);
        chk("rst_misses", misses, 0);
        chk("rst_best", best_rt, 2047);
        chk("rst_last", last_rt, 0);
        chk("rst_over", game_over, 0);
        chk("rst_busy", busy, 0);

        // game 1: hit at 237
        random_value = 5'd5;
        pulse_start();
        chk("start_busy", busy, 1);
        ticks(500);
        chk("arm_led5", led_on, 18'h20);
        ticks(237);
        press(18'h20);
        chk("hit_valid", rt_valid, 1);
        chk("hit_last", last_rt, 237);
        chk("hit_hits", hits, 1);
        chk("hit_best", best_rt, 237);
        chk("hit_led_off", led_on, 0);
        step();
        chk("valid_pulse", rt_valid, 0);

        // wrapped index 20 -> LED 2, wrong button
        random_value = 5'd20;
        ticks(500);
        chk("wrap_led2", led_on, 18'h4);
        press(18'h80);
        chk("wrong_miss", misses, 1);
        chk("wrong_hits", hits, 1);
        chk("wrong_valid", rt_valid, 0);
        step();

        // timeout
        random_value = 5'd3;
        ticks(500);
        ticks(999);
        chk("pre_to_led", led_on, 18'h8);
        chk("pre_to_miss", misses, 1);
        ticks(1);
        chk("to_miss", misses, 2);
        chk("to_led_off", led_on, 0);
        chk("to_busy", busy, 1);

        // press on the timeout tick wins
        random_value = 5'd4;
        ticks(500);
        ticks(999);
        ms_tick = 1'b1;
        buttons = 18'h10;
        step();
        ms_tick = 1'b0;
        buttons = '0;
        chk("race_hits", hits, 2);
        chk("race_last", last_rt, 999);
        chk("race_miss", misses, 2);
        chk("race_best", best_rt, 237);
        step();

        // false start in GAP restarts the gap
        ticks(100);
        press(18'h1);
        chk("fs_miss", misses, 3);
        chk("fs_busy", busy, 1);
        random_value = 5'd6;
        step();
        ticks(499);
        chk("fs_gap_dark", led_on, 0);
        ticks(1);
        chk("fs_gap_lit", led_on, 18'h40);
        press(18'h40);
        chk("rt0_last", last_rt, 0);
        chk("rt0_hits", hits, 3);
        chk("rt0_best", best_rt, 0);
        step();

        for (int i = 7; i < 12; i++) hit_round(5'(i), 50);
        chk("g1_over", game_over, 1);
        chk("g1_busy", busy, 0);
        chk("g1_hits", hits, 8);
        chk("g1_miss", misses, 3);
        chk("g1_best", best_rt, 0);

        // new game from DONE, then saturate misses
        pulse_start();
        chk("g2_over", game_over, 0);
        chk("g2_hits", hits, 0);
        chk("g2_miss", misses, 0);
        chk("g2_best", best_rt, 2047);
        chk("g2_last_kept", last_rt, 50);
        for (int i = 0; i < 260; i++) begin
            press(18'h1);
            step();
        end
        chk("sat_miss", misses, 255);
        random_value = 5'd1;
        ticks(500);
        chk("g2_led1", led_on, 18'h2);

        // reset mid-ARMED
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        chk("mid_rst_led", led_on, 0);
        chk("mid_rst_hits", hits, 0);
        chk("mid_rst_miss", misses, 0);
        chk("mid_rst_best", best_rt, 2047);
        chk("mid_rst_over", game_over, 0);
        chk("mid_rst_busy", busy, 0);
        step();

        // full game of hits
        pulse_start();
        hit_round(5'd2, 300);
        chk("g3_best300", best_rt, 300);
        hit_round(5'd3, 120);
        chk("g3_best120", best_rt, 120);
        chk("g3_last120", last_rt, 120);
        for (int i = 0; i < 8; i++) hit_round(5'(i + 8), 120);
        chk("g3_over", game_over, 1);
        chk("g3_hits", hits, 10);
        chk("g3_miss", misses, 0);
        chk("g3_best", best_rt, 120);
        chk("g3_busy", busy, 0);
        pulse_start();
        chk("g4_over", game_over, 0);
        chk("g4_busy", busy, 1);
        chk("g4_hits", hits, 0);
        chk("g4_best", best_rt, 2047);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
